dec_fpr_bank_sched: RTL
=======================

// Module: dec_fpr_bank_sched
// PURPOSE
//  Issue-side scheduler for the banked FP register file. Keeps a per-register pending-write scoreboard
//  for long-latency FP ops and stalls issue on RAW/WAW hazards. Sequences bank switches: drains
//  outstanding writes, then commits the new bank id through the regfile's wen_bank_id/wr_bank_id port.
// PARAMETERS
//  FPR_BANKS       2   number of FPR banks
//  FPR_BANKS_LOG2  1   width of bank id (>=1)
// PORTS
//  clk            in   1               clock
//  rst            in   1               asynchronous reset, active-high
//  iss_valid      in   1               FP op presented at issue this cycle
//  iss_rden       in   3               read-enable per source (rs1,rs2,rs3)
//  iss_raddr      in   3x5             source FPR addresses
//  iss_wen        in   1               op writes an FPR via long-latency pipe
//  iss_waddr      in   5               destination FPR address
//  iss_stall      out  1               issue must hold (hazard or bank drain)
//  wb_valid       in   1               long-latency FP writeback completes
//  wb_waddr       in   5               writeback destination
//  flush          in   1               pipeline flush: in-flight writes killed
//  sw_req         in   1               bank switch request (level, held until sw_ack)
//  sw_bank_id     in   FPR_BANKS_LOG2  requested bank
//  sw_ack         out  1               one-cycle pulse: switch committed or rejected
//  sw_err         out  1               qualifies sw_ack: request rejected (id >= FPR_BANKS)
//  wen_bank_id    out  1               to regfile: load bank id
//  wr_bank_id     out  FPR_BANKS_LOG2  to regfile: new bank id
//  cur_bank       out  FPR_BANKS_LOG2  committed bank (shadow of regfile bank register)
// BEHAVIOUR
//  Reset: busy[31:1]=0, state=IDLE, cur_bank=0; all outputs 0.
//  Scoreboard: busy[31:1]; address 0 never busy, never set. Issue accepted = iss_valid & ~iss_stall.
//  - Accepted op with iss_wen & waddr!=0 sets busy[waddr] next cycle.
//  - wb_valid clears busy[wb_waddr] next cycle; same-cycle set and clear on same reg: set wins.
//  - flush clears all busy bits next cycle (overrides set and clear).
//  iss_stall (combinational) = iss_valid & (state!=IDLE | any enabled source busy | iss_wen & busy[waddr]).
//  Busy is registered: a writeback and a dependent issue in the same cycle still stalls (1-cycle bubble).
//  FSM IDLE -> DRAIN on sw_req (sampled only in IDLE):
//  - sw_bank_id >= FPR_BANKS: no transition; sw_ack=sw_err=1 for one cycle, then requester must drop.
//  DRAIN: iss_stall forced when iss_valid; ops in flight may retire; -> COMMIT when busy==0
//    (evaluated on registered busy, so min DRAIN dwell is 1 cycle).
//  COMMIT (1 cycle): wen_bank_id=1, wr_bank_id=latched target, sw_ack=1; cur_bank updates next edge; -> IDLE.
//  Switch to current bank still runs the full sequence. Target latched on IDLE->DRAIN; later sw_bank_id ignored.
//  sw_req low in IDLE for >=1 cycle required between requests; sw_req held after ack is not re-accepted
//    until seen low.
//  flush during DRAIN: busy clears, COMMIT follows next cycle (switch is not aborted).
//  Reset mid-sequence: returns to IDLE, no wen_bank_id, no sw_ack.
// CONFIGURATION
//  DEC_FPR_SCHED_STATS_EN defined: adds outputs stat_drain_cyc[31:0], stat_hazard_cyc[31:0];
//    saturating counters of cycles in DRAIN and of cycles with iss_stall due to hazard in IDLE; reset 0.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Package dec_fpr_pkg: typedef enum logic [1:0] {IDLE,DRAIN,COMMIT} fpr_sched_state_e; NUM_FPR=32.
//  Sub-module dec_fpr_scoreboard: busy vector, set/clear/flush, hazard lookup for 3 reads + 1 write.
//  Top: FSM, target latch, cur_bank, sw_req edge guard, optional stats.
// TESTING
//  1) issue wen f5; next cycle issue reading f5 -> iss_stall=1 until cycle after wb_valid f5, then accepted.
//  2) same-cycle wb_valid f7 and issue wen f7 with busy[7]=1 -> stall; next cycle set+clear same reg -> busy[7]=1.
//  3) f3,f9 busy, sw_req id=1 -> DRAIN, stall held; wb f3, wb f9 -> COMMIT: wen_bank_id=1, wr_bank_id=1,
//     sw_ack=1; cur_bank=1 next cycle.
//  4) FPR_BANKS=3, sw_req id=3 -> sw_ack=sw_err=1 one cycle, no wen_bank_id, cur_bank unchanged.
//  5) flush in DRAIN with 4 regs busy -> busy=0 next cycle, COMMIT following cycle.
//  6) rst asserted in DRAIN -> IDLE, busy=0, no ack; random issue/wb/flush vs. reference scoreboard model.

Source files
------------

// File: rtl/dec_fpr_pkg.sv
// Shared types and sizes for the FP register-bank issue scheduler.
package dec_fpr_pkg;

    localparam int NUM_FPR = 32;  // architectural FP registers
    localparam int FPR_AW  = 5;   // FPR address width
    localparam int NUM_SRC = 3;   // source operands per op (rs1, rs2, rs3)

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        COMMIT = 2'd2
    } fpr_sched_state_e;

endpackage

// File: rtl/dec_fpr_scoreboard.sv
// Pending-write scoreboard for long-latency FP ops.
// One busy bit per FPR (f0 is hardwired not-busy). Set on accepted issue,
// cleared on writeback (set wins on the same register), wiped by flush.
// Hazard lookup is purely on the registered busy vector, so a writeback
// never unblocks a dependent op in the same cycle.
module dec_fpr_scoreboard
    import dec_fpr_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           set_en,
    input  logic [FPR_AW-1:0]              set_addr,
    input  logic                           clr_en,
    input  logic [FPR_AW-1:0]              clr_addr,
    input  logic                           flush,
    input  logic [NUM_SRC-1:0]             rden,
    input  logic [NUM_SRC-1:0][FPR_AW-1:0] raddr,
    input  logic                           wen,
    input  logic [FPR_AW-1:0]              waddr,
    output logic                           hazard,
    output logic                           any_busy
);

    logic [NUM_FPR-1:1] busy;
    logic [NUM_FPR-1:1] busy_nxt;
    logic [NUM_FPR-1:0] busy_full;

    // f0 appended as a constant zero so lookups can index with the raw address
    assign busy_full = {busy, 1'b0};
    assign any_busy  = |busy;

    // Next busy vector: clear, then set (set wins), flush overrides both
    always_comb begin
        busy_nxt = busy;
        for (int i = 1; i < NUM_FPR; i++) begin
            if (clr_en && (clr_addr == FPR_AW'(i))) busy_nxt[i] = 1'b0;
            if (set_en && (set_addr == FPR_AW'(i))) busy_nxt[i] = 1'b1;
        end
        if (flush) busy_nxt = '0;
    end

    // Busy register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy <= '0;
        else     busy <= busy_nxt;
    end

    // RAW on any enabled source, WAW on the destination
    always_comb begin
        hazard = wen & busy_full[waddr];
        for (int s = 0; s < NUM_SRC; s++) begin
            hazard = hazard | (rden[s] & busy_full[raddr[s]]);
        end
    end

endmodule

// File: rtl/dec_fpr_bank_sched.sv
// Issue-side scheduler for the banked FP register file.
// Stalls issue on scoreboard hazards, and sequences bank switches:
// IDLE -> DRAIN (wait for all pending writes) -> COMMIT (load regfile bank id).
// Optional build macro DEC_FPR_SCHED_STATS_EN adds saturating cycle counters
// stat_drain_cyc (cycles in DRAIN) and stat_hazard_cyc (hazard stalls in IDLE).
module dec_fpr_bank_sched
    import dec_fpr_pkg::*;
#(
    parameter int FPR_BANKS      = 2,
    parameter int FPR_BANKS_LOG2 = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           iss_valid,
    input  logic [NUM_SRC-1:0]             iss_rden,
    input  logic [NUM_SRC-1:0][FPR_AW-1:0] iss_raddr,
    input  logic                           iss_wen,
    input  logic [FPR_AW-1:0]              iss_waddr,
    output logic                           iss_stall,
    input  logic                           wb_valid,
    input  logic [FPR_AW-1:0]              wb_waddr,
    input  logic                           flush,
    input  logic                           sw_req,
    input  logic [FPR_BANKS_LOG2-1:0]      sw_bank_id,
    output logic                           sw_ack,
    output logic                           sw_err,
    output logic                           wen_bank_id,
    output logic [FPR_BANKS_LOG2-1:0]      wr_bank_id,
    output logic [FPR_BANKS_LOG2-1:0]      cur_bank
`ifdef DEC_FPR_SCHED_STATS_EN
    ,
    output logic [31:0]                    stat_drain_cyc,
    output logic [31:0]                    stat_hazard_cyc
`endif
);

    fpr_sched_state_e              state;
    logic [FPR_BANKS_LOG2-1:0]     target;
    logic [FPR_BANKS_LOG2-1:0]     cur_bank_q;
    logic                          armed;      // sw_req has been seen low since last acceptance
    logic                          err_pulse;  // reject ack, one cycle after the bad request
    logic                          hazard;
    logic                          any_busy;
    logic                          sw_take;
    logic                          id_bad;
    logic                          accept;

    assign sw_take   = (state == IDLE) & sw_req & armed;
    assign id_bad    = 32'(sw_bank_id) >= 32'(FPR_BANKS);
    assign iss_stall = iss_valid & ((state != IDLE) | hazard);
    assign accept    = iss_valid & ~iss_stall;

    assign sw_ack      = (state == COMMIT) | err_pulse;
    assign sw_err      = err_pulse;
    assign wen_bank_id = (state == COMMIT);
    assign wr_bank_id  = (state == COMMIT) ? target : '0;
    assign cur_bank    = cur_bank_q;

    dec_fpr_scoreboard u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (accept & iss_wen),
        .set_addr (iss_waddr),
        .clr_en   (wb_valid),
        .clr_addr (wb_waddr),
        .flush    (flush),
        .rden     (iss_rden),
        .raddr    (iss_raddr),
        .wen      (iss_wen),
        .waddr    (iss_waddr),
        .hazard   (hazard),
        .any_busy (any_busy)
    );

    // Switch FSM: latch target on acceptance, wait out pending writes, commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            target     <= '0;
            cur_bank_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sw_take && !id_bad) begin
                        state  <= DRAIN;
                        target <= sw_bank_id;
                    end
                end
                DRAIN: begin
                    if (!any_busy) state <= COMMIT;
                end
                COMMIT: begin
                    cur_bank_q <= target;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Request edge guard and out-of-range reject pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed     <= 1'b1;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= sw_take & id_bad;
            if (sw_take)      armed <= 1'b0;
            else if (!sw_req) armed <= 1'b1;
        end
    end

`ifdef DEC_FPR_SCHED_STATS_EN
    // Saturating counters: drain dwell and hazard stalls outside a switch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_drain_cyc  <= '0;
            stat_hazard_cyc <= '0;
        end else begin
            if ((state == DRAIN) && (stat_drain_cyc != '1))
                stat_drain_cyc <= stat_drain_cyc + 32'd1;
            if ((state == IDLE) && iss_valid && hazard && (stat_hazard_cyc != '1))
                stat_hazard_cyc <= stat_hazard_cyc + 32'd1;
        end
    end
`endif

endmodule
